// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces press and
// release inside the FSM, and reports the accepted key as a code, a one-cycle tick and a held level.
//
// state      | meaning
// SCAN       | strobe one column per dwell period, look for any low row
// DB_PRESS   | row pattern latched, must stay identical for the full debounce window
// PRESSED    | key accepted, column frozen, wait for all rows high
// DB_RELEASE | rows high, must stay high for the full debounce window
module keypad_scanner #(
    parameter int SCAN_WIDTH = 10,
    parameter int DB_WIDTH   = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } state_t;

    localparam logic [SCAN_WIDTH-1:0] DWELL_ONE = 1;
    localparam logic [DB_WIDTH-1:0]   DB_ONE    = 1;

    state_t                state_q, state_d;
    logic [3:0]            row_meta_q;
    logic [3:0]            row_sync_q;
    logic [3:0]            row_latch_q, row_latch_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [3:0]            col_q, col_d;
    logic [SCAN_WIDTH-1:0] dwell_q, dwell_d;
    logic [DB_WIDTH-1:0]   db_q, db_d;
    logic [3:0]            key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_held_q, key_held_d;

    logic [1:0]            row_idx;
    logic                  rows_idle;
    logic                  pattern_match;
    logic                  dwell_done;
    logic                  db_done;

    assign rows_idle     = (row_sync_q == 4'hF);
    assign pattern_match = (row_sync_q == row_latch_q);
    assign dwell_done    = (dwell_q == '1);
    assign db_done       = (db_q == '1);

    // Lowest-indexed low row wins when several rows are pulled down together.
    always_comb begin
        row_idx = 2'd3;
        if (!row_latch_q[0]) begin
            row_idx = 2'd0;
        end else if (!row_latch_q[1]) begin
            row_idx = 2'd1;
        end else if (!row_latch_q[2]) begin
            row_idx = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_latch_q <= 4'hF;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            dwell_q     <= '0;
            db_q        <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_latch_q <= row_latch_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_latch_d = row_latch_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;

        unique case (state_q)
            SCAN: begin
                if (dwell_done) begin
                    dwell_d = '0;
                    if (!rows_idle) begin
                        row_latch_d = row_sync_q;
                        db_d        = '0;
                        state_d     = DB_PRESS;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_ONE;
                end
            end
            DB_PRESS: begin
                if (!pattern_match) begin
                    db_d    = '0;
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (db_done) begin
                    key_code_d  = {row_idx, col_idx_q};
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                    state_d     = PRESSED;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end
            PRESSED: begin
                if (rows_idle) begin
                    db_d    = '0;
                    state_d = DB_RELEASE;
                end
            end
            DB_RELEASE: begin
                // A bounce back to low resumes the held key without a new tick.
                if (!rows_idle) begin
                    state_d = PRESSED;
                end else if (db_done) begin
                    key_held_d = 1'b0;
                    col_idx_d  = col_idx_q + 2'd1;
                    dwell_d    = '0;
                    db_d       = '0;
                    state_d    = SCAN;
                end else begin
                    db_d = db_q + DB_ONE;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        col_d = ~(4'b0001 << col_idx_d);
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives the rows from the column strobe,
// expected key codes go into a queue, and a negedge monitor pops and compares on every tick.
module tb_keypad_scanner;
    localparam int SW = 4;
    localparam int DW = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    bit         pressed [4][4];
    int         tests = 0;
    int         fails = 0;
    int         ticks = 0;
    int         held_falls = 0;
    logic [3:0] exp_q [$];
    logic [3:0] exp_code;
    logic       prev_valid = 1'b0;
    logic       prev_held = 1'b0;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_WIDTH(SW), .DB_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // A pressed key shorts its row to its column; only the strobed (low) column pulls rows down.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && (col[c] == 1'b0)) row[r] = 1'b0;
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                check(1'b0, "unexpected_tick", 1, 0);
            end else begin
                exp_code = exp_q.pop_front();
                check(key_code == exp_code, "key_code", int'(key_code), int'(exp_code));
            end
            check(key_held == 1'b1, "held_at_tick", int'(key_held), 1);
            check(prev_valid == 1'b0, "tick_one_cycle", int'(prev_valid), 0);
            ticks++;
        end
        if (prev_held && !key_held) held_falls++;
        prev_valid = key_valid;
        prev_held  = key_held;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_tick(input int bound, input string name, output int waited);
        int t0;
        t0 = ticks;
        waited = 0;
        while (ticks == t0 && waited < bound) begin
            cyc(1);
            waited++;
        end
        check(ticks == t0 + 1, name, ticks - t0, 1);
    endtask

    task automatic wait_held_low(input int bound, input string name, output int waited);
        waited = 0;
        while (key_held && waited < bound) begin
            cyc(1);
            waited++;
        end
        check(key_held == 1'b0, name, int'(key_held), 0);
    endtask

    task automatic wait_col(input int idx);
        logic [3:0] one;
        int n;
        one = 4'b0001;
        n = 0;
        while (col != ~(one << idx) && n < 100) begin
            cyc(1);
            n++;
        end
        check(col == ~(one << idx), "wait_col", int'(col), int'(~(one << idx)));
    endtask

    task automatic set_keys(input int r1, input int r2, input int c, input bit v);
        pressed[r1][c] = v;
        pressed[r2][c] = v;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int n, t0, f0, r, r2, c, nb, e;
        logic [3:0] one;
        one = 4'b0001;
        rst_n = 1'b0;
        cyc(3);
        check(col == 4'b1110, "reset_col", int'(col), 14);
        check(key_held == 1'b0, "reset_held", int'(key_held), 0);
        check(key_valid == 1'b0, "reset_valid", int'(key_valid), 0);
        check(key_code == 4'd0, "reset_code", int'(key_code), 0);

        // Idle scan: after n edges the column index is (n / dwell) mod 4.
        rst_n = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            cyc(1);
            check(col == ~(one << ((k / 16) % 4)), "idle_col", int'(col), int'(~(one << ((k / 16) % 4))));
            check(!key_valid && !key_held, "idle_quiet", int'({key_valid, key_held}), 0);
        end

        // Clean press of row 2 in column 1 -> code 9.
        wait_col(1);
        pressed[2][1] = 1'b1;
        exp_q.push_back(4'd9);
        wait_tick(100, "clean_tick", n);
        check(n >= 47 && n <= 51, "clean_latency", n, 49);
        cyc(51);
        pressed[2][1] = 1'b0;
        wait_held_low(60, "clean_release", n);
        check(n >= 33 && n <= 37, "release_latency", n, 35);
        check(col == 4'b1011, "col_after_release", int'(col), 11);

        // Press bounce on row 0 / column 3 -> no tick during bounce, then code 3.
        wait_col(3);
        t0 = ticks;
        for (int k = 0; k < 8; k++) begin
            pressed[0][3] = (k % 2 == 0);
            cyc(5);
        end
        check(ticks == t0, "no_tick_in_bounce", ticks - t0, 0);
        pressed[0][3] = 1'b1;
        exp_q.push_back(4'd3);
        wait_tick(200, "bounce_tick", n);
        cyc(20);

        // Release bounce: held stays up through the glitch, drops once, no new tick.
        t0 = ticks;
        f0 = held_falls;
        pressed[0][3] = 1'b0;
        cyc(10);
        pressed[0][3] = 1'b1;
        cyc(3);
        pressed[0][3] = 1'b0;
        check(key_held == 1'b1, "held_thru_bounce", int'(key_held), 1);
        wait_held_low(80, "bounce_release", n);
        cyc(10);
        check(held_falls - f0 == 1, "single_held_drop", held_falls - f0, 1);
        check(ticks == t0, "no_retick_release", ticks - t0, 0);
        check(key_code == 4'd3, "code_kept_3", int'(key_code), 3);

        // Rows 1 and 3 in column 0 -> lowest row wins; other column ignored while held.
        set_keys(1, 3, 0, 1'b1);
        exp_q.push_back(4'd4);
        wait_tick(200, "multi_row_tick", n);
        pressed[2][2] = 1'b1;
        cyc(100);
        pressed[2][2] = 1'b0;
        cyc(5);
        set_keys(1, 3, 0, 1'b0);
        wait_held_low(80, "multi_release", n);
        check(key_code == 4'd4, "code_kept_4", int'(key_code), 4);
        cyc(10);

        // Randomized presses, optionally two rows in one column, with bounce on both edges.
        for (int it = 0; it < 10; it++) begin
            r  = $urandom_range(0, 3);
            c  = $urandom_range(0, 3);
            r2 = ($urandom_range(0, 2) == 0) ? (r + $urandom_range(1, 3)) % 4 : r;
            e  = 4 * ((r < r2) ? r : r2) + c;
            nb = $urandom_range(0, 6);
            for (int k = 0; k < nb; k++) begin
                set_keys(r, r2, c, (k % 2 == 0));
                cyc($urandom_range(1, 4));
            end
            set_keys(r, r2, c, 1'b1);
            exp_q.push_back(e[3:0]);
            wait_tick(300, "rand_tick", n);
            cyc($urandom_range(5, 60));
            f0 = held_falls;
            nb = $urandom_range(0, 4);
            for (int k = 0; k < nb; k++) begin
                set_keys(r, r2, c, (k % 2 == 1));
                cyc($urandom_range(1, 3));
            end
            set_keys(r, r2, c, 1'b0);
            wait_held_low(80, "rand_release", n);
            cyc(2);
            check(held_falls - f0 == 1, "rand_held_drop", held_falls - f0, 1);
            cyc($urandom_range(0, 30));
        end

        // Reset in the middle of press debounce, key still down -> re-qualified after reset.
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        pressed[2][0] = 1'b1;
        t0 = ticks;
        cyc(36);
        rst_n = 1'b0;
        #1;
        check(col == 4'b1110, "midreset_col", int'(col), 14);
        check(key_held == 1'b0, "midreset_held", int'(key_held), 0);
        check(key_valid == 1'b0, "midreset_valid", int'(key_valid), 0);
        cyc(4);
        check(ticks == t0, "no_tick_across_reset", ticks - t0, 0);
        exp_q.push_back(4'd8);
        rst_n = 1'b1;
        wait_tick(100, "requalify_tick", n);
        check(n >= 47 && n <= 51, "requalify_latency", n, 49);
        pressed[2][0] = 1'b0;
        wait_held_low(80, "final_release", n);
        cyc(5);

        check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad through a time-multiplexed column scan: drives one active-low column at a time and samples the four active-low rows.
- Debounces each press and release in-FSM; emits a key code with a one-cycle valid tick and a held level.
- Input-side counterpart to the multiplexed seven-segment display driver.
- Feeds edge counters and hex display logic in top-level wrappers.

Parameters:
SCAN_WIDTH, 10, width of the column dwell counter; dwell is 2^SCAN_WIDTH cycles per column.
DB_WIDTH, 21, width of the debounce counter; stable window is 2^DB_WIDTH cycles (~21 ms at 100 MHz).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
row  input  4  keypad rows, active-low, externally pulled up
col  output  4  keypad column drive, active-low, exactly one bit low at all times
key_code  output  4  last accepted key, 4*row_idx + col_idx
key_valid  output  1  one-cycle tick per accepted press
key_held  output  1  high from accepted press until accepted release

Behaviour:
- Reset (reset=0, async):
  - state=SCAN, col_idx=0, col=4'b1110
  - both counters=0, row synchronizer FFs=4'hF, latched row pattern=4'hF
  - key_code=0, key_valid=0, key_held=0
- Row path:
  - row passes through a 2-FF synchronizer (row_sync); 2-cycle latency.
  - All decisions use row_sync only.
- col is registered, equals ~(4'b0001 << col_idx), and changes only on column advance.
- SCAN:
  - Dwell counter increments every cycle.
  - At counter == all-ones, with row_sync != 4'hF: latch row_sync, clear counter, go to DB_PRESS; column held.
  - At counter == all-ones, with row_sync == 4'hF: col_idx += 1 (3 wraps to 0); counter wraps to 0.
- DB_PRESS:
  - Counter increments each cycle.
  - If row_sync != latched pattern on any cycle: clear counter, return to SCAN on the same column.
  - At counter == all-ones with pattern still matching: go to PRESSED.
    - key_code = 4*row_idx + col_idx, where row_idx = lowest-indexed low bit of the latched pattern (multiple rows low: lowest index wins).
    - key_valid=1 for exactly that one cycle; key_held=1.
- PRESSED:
  - Column held, no scanning.
  - When row_sync == 4'hF: clear counter, go to DB_RELEASE.
- DB_RELEASE:
  - If row_sync != 4'hF on any cycle: return to PRESSED, with no new key_valid and key_code unchanged.
  - At counter == all-ones: key_held=0, col_idx += 1, counter=0, go to SCAN.
- Keys in other columns pressed while a key is PRESSED are ignored until release completes.
- key_code holds its value until the next accepted press; it is not cleared on release.
- key_valid never asserts outside the DB_PRESS -> PRESSED transition. At most one tick per press, independent of bounce.
- Reset asserted mid-debounce or mid-press: immediate return to reset values, with no key_valid emitted.

Test Plan:
Bench uses SCAN_WIDTH=4, DB_WIDTH=5.
1. Release reset, rows idle 4'hF for 200 cycles -> col cycles 1110, 1101, 1011, 0111, 1110, advancing every 16 cycles; key_valid=0, key_held=0 throughout.
2. Clean press of row 2 while col_idx=1, held 100 cycles, then release -> exactly one key_valid tick with key_code=9, arriving ~32 cycles after the dwell-end sample. key_held=1 until 32 cycles after rows return to 4'hF; column then advances to col_idx=2.
3. Press row 0 at col_idx=3 with row toggling every 5 cycles for 40 cycles, then stable 60 cycles -> no tick during bounce, then exactly one key_valid with key_code=3.
4. Release bounce: while key 3 is held, rows go 4'hF for 10 cycles, low 3 cycles, then 4'hF for 40 cycles -> key_held stays 1 through the bounce and drops once; no second key_valid.
5. Rows 1 and 3 both low in column 0 -> key_code=4 (lowest row wins); a press in column 2 while held -> ignored.
6. Assert reset during DB_PRESS (counter=20) -> col=1110, key_held=0, key_valid=0 immediately; no tick after reset deasserts unless the press is re-qualified.
